aes_encrypt_iter: RTL
=====================

// Module: aes_encrypt_iter
// PURPOSE
//  Iterative AES block encryptor (FIPS-197 Cipher), companion to the iterative decryptor.
//  Accepts one 128-bit plaintext block via valid/ready and applies one full round per clock.
//  Returns the ciphertext via valid/ready; consumes the pre-expanded key schedule from KeyExpansion.
//  AES-128/192/256 are selected by parameters.
// PARAMETERS
//  Nk  4   key length in 32-bit words (4/6/8); any other value is an elaboration error
//  Nr  10  number of rounds; must equal Nk+6, otherwise an elaboration error
// PORTS
//  clk        in   1            clock; all state updates on rising edge
//  reset      in   1            reset, synchronous, active-high
//  in_valid   in   1            plaintext block offered
//  in_ready   out  1            block accepted when in_valid && in_ready
//  in_data    in   128          plaintext; bits [127:120] = FIPS byte 0 (column-major)
//  all_keys   in   (Nr+1)*128   round key i at all_keys[(Nr-i)*128 +: 128] (round key 0 at MSBs)
//  out_valid  out  1            ciphertext available
//  out_ready  in   1            consumer accepts when out_valid && out_ready
//  out_data   out  128          ciphertext, same byte order as in_data
// BEHAVIOUR
//  - FSM: IDLE -> RUN -> DONE -> IDLE. in_ready = (fsm==IDLE); out_valid = (fsm==DONE).
//  - Reset: fsm=IDLE, round=0, state reg=0; in_ready=1, out_valid=0, out_data=0.
//  - IDLE + in_valid: state <= in_data ^ rk0; round <= 1; go to RUN.
//  - RUN, round r in 1..Nr-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[r]; round++.
//  - RUN, round Nr: same transform without MixColumns; go to DONE.
//  - Latency: out_valid rises exactly Nr cycles after the accept edge (10/12/14).
//  - DONE: out_data = state reg, held stable while out_valid && !out_ready.
//  - DONE + out_ready: go to IDLE. in_ready rises the next cycle; no accept in the same cycle (no overlap).
//  - Round counter width $clog2(Nr+1); it never exceeds Nr. GF(2^8) mult uses xtime mod 0x11B.
//  - all_keys must be stable from accept until the output handshake. The block does not sample it.
//  - Reset mid-operation (RUN or DONE): the block is abandoned and returns to the reset values next cycle.
//  - in_valid while busy is ignored (not accepted). The producer must hold in_data until accepted.
// CONFIGURATION
//  - Macro AES_ENC_SBOX_PIPE_EN:
//    - Defined: a register follows SubBytes, and each round takes 2 cycles (phase bit).
//      Latency is 2*Nr cycles. Handshake rules are unchanged. The phase bit resets to 0.
//    - Undefined: single-cycle rounds, latency Nr. The phase bit and extra register are absent.
// STRUCTURE
//  - Package aes_pkg: SBOX table/function, xtime and gf_mul functions, and the fsm state enum
//    (IDLE/RUN/DONE), shared with the decryptor and KeyExpansion.
//  - Sub-module aes_enc_round (combinational). Inputs: state, round_key, last_round. Output: next state.
//    It is instantiated once.
//  - The top holds the FSM, the round counter, the state register and the key-slice mux.
// TESTING
//  1. Nk=4: pt 00112233445566778899aabbccddeeff, key 000102..0f
//     -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid 10 cycles after accept.
//  2. Nk=6: same pt, key 000102..17
//     -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
//     Nk=8: key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
//  3. Backpressure: hold out_ready=0 for 5 cycles after out_valid
//     -> out_data stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
//  4. Back-to-back: two blocks with in_valid held high
//     -> second accepted only after the first output handshake; both ciphertexts match the FIPS vectors.
//  5. Reset asserted at round 5 -> next cycle in_ready=1, out_valid=0, out_data=0.
//     A following block encrypts correctly.
//  6. With AES_ENC_SBOX_PIPE_EN: test 1 -> same ciphertext, out_valid 20 cycles after accept.
//     An in_valid pulse while busy is not accepted.

Source files
------------

// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module  : aes_pkg
// Brief   : Shared AES definitions: the S-box table, GF(2^8) helpers and the
//           IDLE/RUN/DONE state enum used by the encryptor, decryptor and
//           KeyExpansion.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Multiply by x modulo the AES polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_enc_round.sv
//------------------------------------------------------------------------------
// Module  : aes_enc_round
// Brief   : One combinational AES cipher round: SubBytes, ShiftRows,
//           MixColumns (skipped on the last round) and AddRoundKey.
//           With AES_ENC_SBOX_PIPE_EN defined, SubBytes is exported and the
//           rest of the round works on the externally registered bytes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last_round,
`ifdef AES_ENC_SBOX_PIPE_EN
  input  logic [127:0] i_sub_q,
  output logic [127:0] o_sub_d,
`endif
  output logic [127:0] o_next_state
);

  logic [127:0] w_sub;
  logic [127:0] w_sub_use;
  logic [7:0]   w_sr [16];
  logic [7:0]   w_mc [16];

  // SubBytes on every byte of the incoming state.
  always_comb begin
    w_sub = '0;
    for (int i = 0; i < 16; i++) w_sub[127 - 8*i -: 8] = sbox(i_state[127 - 8*i -: 8]);
  end

`ifdef AES_ENC_SBOX_PIPE_EN
  assign o_sub_d   = w_sub;
  assign w_sub_use = i_sub_q;
`else
  assign w_sub_use = w_sub;
`endif

  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
  always_comb begin
    w_sr = '{default: 8'h00};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[4*c + r] = w_sub_use[127 - 8*(4*((c + r) % 4) + r) -: 8];
  end

  // MixColumns: each column multiplied by the circulant {02,03,01,01}.
  always_comb begin
    w_mc = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c]     = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                    ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c + 1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                    ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c + 2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                    ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c + 3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1]
                    ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
  end

  // AddRoundKey on either the mixed or the merely shifted columns.
  always_comb begin
    o_next_state = '0;
    for (int i = 0; i < 16; i++)
      o_next_state[127 - 8*i -: 8] = (i_last_round ? w_sr[i] : w_mc[i])
                                   ^ i_round_key[127 - 8*i -: 8];
  end

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_iter.sv
//------------------------------------------------------------------------------
// Module  : aes_encrypt_iter
// Brief   : Iterative AES-128/192/256 block encryptor, one round per clock,
//           valid/ready on both sides, pre-expanded key schedule input.
//           Build option AES_ENC_SBOX_PIPE_EN: register after SubBytes, two
//           cycles per round.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [(Nr+1)*128-1:0] all_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data
);

  localparam int              c_round_w    = $clog2(Nr + 1);
  localparam logic [c_round_w-1:0] c_last_round = c_round_w'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_encrypt_iter: Nk must be 4, 6 or 8");
  end
  if (Nr != Nk + 6) begin : g_bad_nr
    $error("aes_encrypt_iter: Nr must equal Nk+6");
  end

  fsm_e                 r_fsm;
  fsm_e                 w_fsm_next;
  logic [c_round_w-1:0] r_round;
  logic [127:0]         r_state;
  logic [127:0]         w_rk0;
  logic [127:0]         w_rk;
  logic [127:0]         w_round_out;
  logic                 w_last;
  logic                 w_step;

  // Round key 0 sits at the MSBs; round key r at slice Nr-r.
  assign w_rk0  = all_keys[Nr*128 +: 128];
  assign w_rk   = all_keys[(Nr - int'(r_round))*128 +: 128];
  assign w_last = (r_round == c_last_round);

`ifdef AES_ENC_SBOX_PIPE_EN
  logic         r_phase;
  logic [127:0] r_sub;
  logic [127:0] w_sub_d;

  assign w_step = r_phase;

  // Phase 0 captures SubBytes, phase 1 finishes the round.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_sub   <= '0;
    end else if (r_fsm == RUN) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_sub <= w_sub_d;
    end
  end

  aes_enc_round u_round (
    .i_state      (r_state),
    .i_round_key  (w_rk),
    .i_last_round (w_last),
    .i_sub_q      (r_sub),
    .o_sub_d      (w_sub_d),
    .o_next_state (w_round_out)
  );
`else
  assign w_step = 1'b1;

  aes_enc_round u_round (
    .i_state      (r_state),
    .i_round_key  (w_rk),
    .i_last_round (w_last),
    .o_next_state (w_round_out)
  );
`endif

  // State register for the FSM.
  always_ff @(posedge clk) begin
    if (reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = RUN;
      end
      RUN: begin
        if (w_step && w_last) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_next = IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  // Cipher state and round counter; the counter saturates at Nr.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_round <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_data ^ w_rk0;
            r_round <= c_round_w'(1);
          end
        end
        RUN: begin
          if (w_step) begin
            r_state <= w_round_out;
            if (!w_last) r_round <= r_round + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_round <= '0;
        end
        default: r_round <= '0;
      endcase
    end
  end

  assign out_data = r_state;

endmodule

`default_nettype wire
